// File: rtl/parking_gate_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : parking_gate_ctrl
// Purpose  : Single-lane parking entry controller. It checks a strobed keypad
//            PIN with a retry limit and a PIN-entry timeout, drives the gate
//            and alarm outputs, and tracks lot occupancy against a capacity.
// Revision : 1.0 - parametrised successor with strobed PIN and occupancy
// ============================================================================
module parking_gate_ctrl #(
    parameter int PIN_W       = 8,
    parameter int PIN_VALUE   = 72,
    parameter int MAX_TRIES   = 3,
    parameter int TIMEOUT_CYC = 1024,
    parameter int CAPACITY    = 16
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            senr_e,
    input  logic                            senr_x,
    input  logic                            car_exit,
    input  logic [PIN_W-1:0]                pin,
    input  logic                            pin_vld,
    output logic                            gate_o,
    output logic                            gate_cls,
    output logic                            alm_pin,
    output logic                            alm_blkg,
    output logic                            full,
    output logic [$clog2(CAPACITY+1)-1:0]   occupancy,
    output logic [2:0]                      fail_cnt
);

    localparam int c_occ_w = $clog2(CAPACITY + 1);
    localparam int c_tmo_w = $clog2(TIMEOUT_CYC);

    // PIN_VALUE is truncated to the keypad width before comparison
    localparam logic [PIN_W-1:0]   c_pin       = PIN_W'(PIN_VALUE);
    localparam logic [2:0]         c_max_tries = 3'(MAX_TRIES);
    localparam logic [c_occ_w-1:0] c_capacity  = c_occ_w'(CAPACITY);
    localparam logic [c_tmo_w-1:0] c_tmo_last  = c_tmo_w'(TIMEOUT_CYC - 1);

    // One-hot state encoding
    localparam logic [5:0] c_st_idle  = 6'b000001;
    localparam logic [5:0] c_st_wait  = 6'b000010;
    localparam logic [5:0] c_st_open  = 6'b000100;
    localparam logic [5:0] c_st_close = 6'b001000;
    localparam logic [5:0] c_st_alarm = 6'b010000;
    localparam logic [5:0] c_st_block = 6'b100000;

    logic [5:0]         r_state;
    logic [5:0]         w_state_nxt;
    logic [c_tmo_w-1:0] r_tmo;
    logic [2:0]         r_fail;
    logic [c_occ_w-1:0] r_occ;

    logic               w_pin_ok;
    logic               w_pin_bad;
    logic [2:0]         w_fail_inc;
    logic               w_full;
    logic               w_occ_inc;

    assign w_pin_ok   = pin_vld && (pin == c_pin);
    assign w_pin_bad  = pin_vld && (pin != c_pin);
    assign w_fail_inc = r_fail + 3'd1;
    assign w_full     = (r_occ == c_capacity);
    // A vehicle counts as parked only when it clears the gate cleanly
    assign w_occ_inc  = (r_state == c_st_open) && senr_x && !senr_e;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; a PIN strobe outranks the timeout in WAIT_PIN
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (senr_e && !w_full) begin
                    w_state_nxt = c_st_wait;
                end
            end
            c_st_wait: begin
                if (w_pin_ok) begin
                    w_state_nxt = c_st_open;
                end else if (w_pin_bad) begin
                    if (w_fail_inc == c_max_tries) begin
                        w_state_nxt = c_st_alarm;
                    end
                end else if (r_tmo == c_tmo_last) begin
                    w_state_nxt = c_st_idle;
                end
            end
            c_st_alarm: begin
                if (w_pin_ok) begin
                    w_state_nxt = c_st_open;
                end
            end
            c_st_open: begin
                if (senr_e && senr_x) begin
                    w_state_nxt = c_st_block;
                end else if (senr_x) begin
                    w_state_nxt = c_st_close;
                end
            end
            c_st_block: begin
                if (w_pin_ok) begin
                    w_state_nxt = c_st_close;
                end
            end
            c_st_close: begin
                w_state_nxt = c_st_idle;
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // Moore output decode straight from the state register
    always_comb begin
        gate_o   = (r_state == c_st_open) || (r_state == c_st_block);
        gate_cls = (r_state == c_st_close);
        alm_pin  = (r_state == c_st_alarm);
        alm_blkg = (r_state == c_st_block);
    end

    // Silent-cycle counter: only runs in WAIT_PIN, restarted by any strobe
    always_ff @(posedge clock) begin
        if (reset) begin
            r_tmo <= '0;
        end else if ((r_state != c_st_wait) || pin_vld) begin
            r_tmo <= '0;
        end else begin
            r_tmo <= r_tmo + 1'b1;
        end
    end

    // Consecutive wrong-PIN counter; parks at MAX_TRIES while in PIN_ALARM
    always_ff @(posedge clock) begin
        if (reset) begin
            r_fail <= 3'd0;
        end else if (((r_state == c_st_wait) || (r_state == c_st_alarm)) && w_pin_ok) begin
            r_fail <= 3'd0;
        end else if ((r_state == c_st_wait) && w_pin_bad) begin
            r_fail <= w_fail_inc;
        end
    end

    // Occupancy: entry and exit in the same cycle cancel out
    always_ff @(posedge clock) begin
        if (reset) begin
            r_occ <= '0;
        end else if (w_occ_inc && car_exit) begin
            r_occ <= r_occ;
        end else if (w_occ_inc && (r_occ != c_capacity)) begin
            r_occ <= r_occ + 1'b1;
        end else if (car_exit && (r_occ != '0)) begin
            r_occ <= r_occ - 1'b1;
        end
    end

    assign full      = w_full;
    assign occupancy = r_occ;
    assign fail_cnt  = r_fail;

endmodule
`default_nettype wire
